id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the pipelined MIPS datapath.
- Sits directly downstream of the main control decoder and consumes its EX (4b), MEM (3b) and WB (2b) control bundles, together with the ID-stage operands.
- Registers the bundles and operands for the EX stage, detects load-use hazards and inserts bubbles, and counts stall and bubble events for debug.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_W, 5, register-address width
- CNT_W, 16, width of the saturating event counters

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- ex_ctrl_d  in  4  {regDest, aluOp[1:0], aluSrc} from the control decoder
- mem_ctrl_d  in  3  {branch, memRead, memWrite}
- wb_ctrl_d  in  2  {regWrite, memToReg}
- flush_id  in  1  instruction currently in ID is squashed (branch taken)
- rd1_d, rd2_d  in  DATA_W  register-file read data
- imm_d  in  DATA_W  sign-extended immediate
- pc4_d  in  DATA_W  PC+4 of the ID instruction
- rs_d, rt_d, rd_d  in  REG_W  register fields of the ID instruction
- ex_ctrl_q  out  4  registered EX bundle
- mem_ctrl_q  out  3  registered MEM bundle
- wb_ctrl_q  out  2  registered WB bundle
- rd1_q, rd2_q, imm_q, pc4_q  out  DATA_W  registered operands
- rs_q, rt_q, rd_q  out  REG_W  registered register fields
- valid_q  out  1  EX slot holds a real instruction (0 = bubble)
- pc_write  out  1  PC update enable (0 = hold)
- if_id_write  out  1  IF/ID register update enable (0 = hold)
- stall_cnt  out  CNT_W  load-use stalls taken, saturating
- bubble_cnt  out  CNT_W  bubbles inserted (stall or flush), saturating

Behaviour:
- Reset (reset=0, asynchronous):
  - All *_q outputs, valid_q and both counters go to 0.
  - pc_write and if_id_write are combinational, so during reset they read 1 (no hazard, because mem_ctrl_q[1]=0).
- Hazard detection (combinational, from registered state and current ID fields):
  - hazard = mem_ctrl_q[1] & valid_q & (rt_q != 0) & ((rt_q == rs_d) | (rt_q == rt_d)) & ~flush_id
  - pc_write = if_id_write = ~hazard
- Register update on each rising edge, in priority order:
  1. flush_id=1: insert bubble.
     - ex/mem/wb_ctrl_q <= 0, valid_q <= 0.
     - Data and register-field registers still load their _d values; they are don't-care when valid_q=0.
     - bubble_cnt++.
  2. hazard=1: insert bubble exactly as in case 1; stall_cnt++ and bubble_cnt++.
     - Because IF/ID and PC hold, the same ID instruction is presented again next cycle.
     - With valid_q now 0 the hazard clears, so a load-use stall lasts exactly 1 cycle.
  3. Otherwise: all _q registers <= their _d inputs, valid_q <= 1.
- Latency: 1 cycle from ID inputs to the EX-side outputs.
- Counters:
  - Increment by 1 per event and saturate at 2^CNT_W-1 (no wrap).
  - stall_cnt and bubble_cnt both increment on the same edge when a stall bubble is inserted.
- Simultaneous flush_id and hazard: flush wins, hazard is masked, pc_write=1, only bubble_cnt increments.
- Back-to-back loads: each dependent consumer costs exactly 1 stall cycle.
- An independent instruction after a load produces no stall.
- Writes to register $0 (rt_q=0) never cause a stall.
- Reset asserted mid-stall: outputs clear immediately; after release, pc_write=1.
- Unknown opcodes: the decoder supplies its bundles unchanged and this stage passes them through without interpretation.

Decomposition:
- Shared package (mips_pkg):
  - bundle widths EX_W=4, MEM_W=3, WB_W=2
  - bit indices: EX_REGDST=3, EX_ALUOP_HI=2, EX_ALUOP_LO=1, EX_ALUSRC=0, MEM_BRANCH=2, MEM_READ=1, MEM_WRITE=0, WB_REGWRITE=1, WB_MEMTOREG=0
  - constant REG_ZERO=0
- Sub-module:
  - sat_counter (parameter CNT_W; inputs clock, reset, inc; output count), instantiated twice.
  - Hazard compare stays inline.

Test Plan:
- Reset: hold reset=0 with random inputs. Expect all _q=0, valid_q=0, counters=0, pc_write=1. Release reset, apply an R-type (ex=4'b1100, wb=2'b10). Next edge: ex_ctrl_q=4'b1100, valid_q=1.
- Load-use: lw with ctrl {ex=0001, mem=010, wb=11}, rt=8, then an add with rs=8. Expect pc_write=if_id_write=0 for exactly 1 cycle, one bubble (all ctrl_q=0), then the add is registered. stall_cnt=1, bubble_cnt=1.
- No hazard: lw rt=8, then add with rs=9, rt=10. Expect pc_write stays 1, no bubble, stall_cnt=0. Separately, lw rt=0 then rs=0 gives no stall.
- Flush: beq (mem=100) then flush_id=1 on the next ID instruction. Expect that slot registered as a bubble, valid_q=0, bubble_cnt=1.
- Flush and hazard together: lw rt=5, then ID rs=5 with flush_id=1. Expect pc_write=1, bubble, stall_cnt=0, bubble_cnt=1.
- Saturation and async reset: with CNT_W=2, force 5 consecutive flushes. Expect bubble_cnt=3 and no wrap. Then pulse reset low mid-cycle and expect counters=0 before the next clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS datapath.
// Provides the control-bundle widths and the bit positions of the
// individual control signals within each bundle, plus the $zero
// register index used by hazard detection.
package mips_pkg;

    localparam int EX_W  = 4;
    localparam int MEM_W = 3;
    localparam int WB_W  = 2;

    // EX bundle: {regDest, aluOp[1:0], aluSrc}
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

    // MEM bundle: {branch, memRead, memWrite}
    localparam int MEM_BRANCH = 2;
    localparam int MEM_READ   = 1;
    localparam int MEM_WRITE  = 0;

    // WB bundle: {regWrite, memToReg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam int REG_ZERO = 0;

    typedef logic [EX_W-1:0]  ex_ctrl_t;
    typedef logic [MEM_W-1:0] mem_ctrl_t;
    typedef logic [WB_W-1:0]  wb_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline debug event counts.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low reset, clears the count
//   inc   - count one event on this edge
//   count - current value; holds at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the pipelined MIPS datapath.
// Registers the EX/MEM/WB control bundles, operands and register fields
// from the ID stage, detects load-use hazards against the instruction
// currently in EX, and inserts bubbles on a stall or a branch flush.
// Ports:
//   clock, reset            - clock, asynchronous active-low reset
//   ex/mem/wb_ctrl_d        - control bundles from the decoder
//   flush_id                - squash the instruction in ID
//   rd1_d, rd2_d, imm_d, pc4_d, rs_d, rt_d, rd_d - ID-stage operands/fields
//   *_q                     - registered copies for the EX stage
//   valid_q                 - EX slot holds a real instruction
//   pc_write, if_id_write   - front-end update enables (0 = hold)
//   stall_cnt, bubble_cnt   - saturating debug event counters
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        ex_ctrl_d,
    input  logic [2:0]        mem_ctrl_d,
    input  logic [1:0]        wb_ctrl_d,
    input  logic              flush_id,
    input  logic [DATA_W-1:0] rd1_d,
    input  logic [DATA_W-1:0] rd2_d,
    input  logic [DATA_W-1:0] imm_d,
    input  logic [DATA_W-1:0] pc4_d,
    input  logic [REG_W-1:0]  rs_d,
    input  logic [REG_W-1:0]  rt_d,
    input  logic [REG_W-1:0]  rd_d,
    output logic [3:0]        ex_ctrl_q,
    output logic [2:0]        mem_ctrl_q,
    output logic [1:0]        wb_ctrl_q,
    output logic [DATA_W-1:0] rd1_q,
    output logic [DATA_W-1:0] rd2_q,
    output logic [DATA_W-1:0] imm_q,
    output logic [DATA_W-1:0] pc4_q,
    output logic [REG_W-1:0]  rs_q,
    output logic [REG_W-1:0]  rt_q,
    output logic [REG_W-1:0]  rd_q,
    output logic              valid_q,
    output logic              pc_write,
    output logic              if_id_write,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic      hazard;
    logic      bubble;
    ex_ctrl_t  ex_ctrl_nxt;
    mem_ctrl_t mem_ctrl_nxt;
    wb_ctrl_t  wb_ctrl_nxt;
    logic      valid_nxt;

    // A load in EX whose destination feeds the ID instruction forces a
    // one-cycle bubble. valid_q gates the check so the bubble itself
    // cannot re-trigger the stall; a flush makes the ID instruction moot.
    always_comb begin
        hazard = mem_ctrl_q[MEM_READ] & valid_q
               & (rt_q != REG_W'(REG_ZERO))
               & ((rt_q == rs_d) | (rt_q == rt_d))
               & ~flush_id;
        bubble = flush_id | hazard;

        ex_ctrl_nxt  = ex_ctrl_d;
        mem_ctrl_nxt = mem_ctrl_d;
        wb_ctrl_nxt  = wb_ctrl_d;
        valid_nxt    = 1'b1;
        if (bubble) begin
            ex_ctrl_nxt  = '0;
            mem_ctrl_nxt = '0;
            wb_ctrl_nxt  = '0;
            valid_nxt    = 1'b0;
        end
    end

    assign pc_write    = ~hazard;
    assign if_id_write = ~hazard;

    // Data and register fields load unconditionally; they are ignored
    // downstream whenever valid_q is low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_ctrl_q  <= '0;
            mem_ctrl_q <= '0;
            wb_ctrl_q  <= '0;
            valid_q    <= 1'b0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            pc4_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
        end else begin
            ex_ctrl_q  <= ex_ctrl_nxt;
            mem_ctrl_q <= mem_ctrl_nxt;
            wb_ctrl_q  <= wb_ctrl_nxt;
            valid_q    <= valid_nxt;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            imm_q      <= imm_d;
            pc4_q      <= pc4_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (hazard),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (bubble),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock;
    logic          reset;
    logic [3:0]    ex_ctrl_d;
    logic [2:0]    mem_ctrl_d;
    logic [1:0]    wb_ctrl_d;
    logic          flush_id;
    logic [DW-1:0] rd1_d, rd2_d, imm_d, pc4_d;
    logic [RW-1:0] rs_d, rt_d, rd_d;
    logic [3:0]    ex_ctrl_q;
    logic [2:0]    mem_ctrl_q;
    logic [1:0]    wb_ctrl_q;
    logic [DW-1:0] rd1_q, rd2_q, imm_q, pc4_q;
    logic [RW-1:0] rs_q, rt_q, rd_q;
    logic          valid_q, pc_write, if_id_write;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    id_ex_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .ex_ctrl_d(ex_ctrl_d), .mem_ctrl_d(mem_ctrl_d), .wb_ctrl_d(wb_ctrl_d),
        .flush_id(flush_id),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .pc4_d(pc4_d),
        .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
        .ex_ctrl_q(ex_ctrl_q), .mem_ctrl_q(mem_ctrl_q), .wb_ctrl_q(wb_ctrl_q),
        .rd1_q(rd1_q), .rd2_q(rd2_q), .imm_q(imm_q), .pc4_q(pc4_q),
        .rs_q(rs_q), .rt_q(rt_q), .rd_q(rd_q),
        .valid_q(valid_q), .pc_write(pc_write), .if_id_write(if_id_write),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: what sits in the EX slot, and the event tallies.
    typedef struct {
        logic [3:0] ex; logic [2:0] mem; logic [1:0] wb;
        logic [DW-1:0] rd1, rd2, imm, pc4;
        logic [RW-1:0] rs, rt, rd;
        bit   real_instr;
        int   stalls, bubbles;
    } slot_t;
    slot_t m;

    // Stall when the instruction in EX is a real load writing a non-zero
    // register that the ID instruction reads, unless ID is being squashed.
    function automatic bit load_use();
        bit is_load = (m.mem[1] == 1'b1) && m.real_instr;
        bit reads   = (m.rt == rs_d) || (m.rt == rt_d);
        return is_load && (m.rt != 0) && reads && !flush_id;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m.ex = 0; m.mem = 0; m.wb = 0;
            m.rd1 = 0; m.rd2 = 0; m.imm = 0; m.pc4 = 0;
            m.rs = 0; m.rt = 0; m.rd = 0;
            m.real_instr = 0; m.stalls = 0; m.bubbles = 0;
        end else begin
            bit stall;
            stall = load_use();
            if (flush_id || stall) begin
                m.ex = 0; m.mem = 0; m.wb = 0; m.real_instr = 0;
                if (m.bubbles < CMAX) m.bubbles++;
                if (stall && m.stalls < CMAX) m.stalls++;
            end else begin
                m.ex = ex_ctrl_d; m.mem = mem_ctrl_d; m.wb = wb_ctrl_d;
                m.real_instr = 1;
            end
            m.rd1 = rd1_d; m.rd2 = rd2_d; m.imm = imm_d; m.pc4 = pc4_d;
            m.rs = rs_d; m.rt = rt_d; m.rd = rd_d;
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("ex_ctrl_q", ex_ctrl_q, m.ex);
            check("mem_ctrl_q", mem_ctrl_q, m.mem);
            check("wb_ctrl_q", wb_ctrl_q, m.wb);
            check("valid_q", valid_q, m.real_instr);
            check("rd1_q", rd1_q, m.rd1);
            check("rd2_q", rd2_q, m.rd2);
            check("imm_q", imm_q, m.imm);
            check("pc4_q", pc4_q, m.pc4);
            check("rs_q", rs_q, m.rs);
            check("rt_q", rt_q, m.rt);
            check("rd_q", rd_q, m.rd);
            check("pc_write", pc_write, !load_use());
            check("if_id_write", if_id_write, !load_use());
            check("stall_cnt", stall_cnt, m.stalls);
            check("bubble_cnt", bubble_cnt, m.bubbles);
        end
    end

    task automatic drive(input logic [3:0] ex, input logic [2:0] mem, input logic [1:0] wb,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic fl);
        ex_ctrl_d = ex; mem_ctrl_d = mem; wb_ctrl_d = wb;
        rs_d = rs; rt_d = rt; rd_d = rd; flush_id = fl;
        rd1_d = $urandom; rd2_d = $urandom; imm_d = $urandom; pc4_d = $urandom;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(4'($urandom), 3'($urandom), 2'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), 1'($urandom));
        @(negedge clock);
        check("rst_valid", valid_q, 1'b0);
        check("rst_ex", ex_ctrl_q, 4'h0);
        check("rst_mem", mem_ctrl_q, 3'h0);
        check("rst_cnt", {stall_cnt, bubble_cnt}, '0);
        check("rst_pc_write", pc_write, 1'b1);
        tick();
        reset = 1'b1;
        drive(4'b0000, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        drive(4'b0000, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        cmp_en = 1;
        do_reset();

        // R-type after reset
        drive(4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        check("rtype_ex", ex_ctrl_q, 4'b1100);
        check("rtype_valid", valid_q, 1'b1);

        // Load-use: lw rt=8, then add rs=8
        do_reset();
        drive(4'b0001, 3'b010, 2'b11, 5'd1, 5'd8, 5'd0, 1'b0);
        tick();
        drive(4'b1100, 3'b000, 2'b10, 5'd8, 5'd9, 5'd10, 1'b0);
        #1;
        check("lu_pc_write", pc_write, 1'b0);
        check("lu_if_id_write", if_id_write, 1'b0);
        tick();
        check("lu_bubble_ctrl", {ex_ctrl_q, mem_ctrl_q, wb_ctrl_q}, 9'd0);
        check("lu_bubble_valid", valid_q, 1'b0);
        check("lu_stall_cnt", stall_cnt, 2'd1);
        check("lu_bubble_cnt", bubble_cnt, 2'd1);
        check("lu_release", pc_write, 1'b1);
        tick();
        check("lu_add_ex", ex_ctrl_q, 4'b1100);
        check("lu_add_rs", rs_q, 5'd8);
        check("lu_add_valid", valid_q, 1'b1);
        check("lu_stall_final", stall_cnt, 2'd1);

        // Back-to-back loads with dependent consumers: one stall each
        drive(4'b0001, 3'b010, 2'b11, 5'd8, 5'd11, 5'd0, 1'b0);
        tick();
        drive(4'b1100, 3'b000, 2'b10, 5'd4, 5'd11, 5'd12, 1'b0);
        tick();
        tick();
        check("b2b_stall_cnt", stall_cnt, 2'd2);

        // Independent instruction after a load, and a load to $0
        do_reset();
        drive(4'b0001, 3'b010, 2'b11, 5'd1, 5'd8, 5'd0, 1'b0);
        tick();
        drive(4'b1100, 3'b000, 2'b10, 5'd9, 5'd10, 5'd11, 1'b0);
        #1;
        check("indep_pc_write", pc_write, 1'b1);
        tick();
        check("indep_valid", valid_q, 1'b1);
        check("indep_stall", stall_cnt, 2'd0);
        drive(4'b0001, 3'b010, 2'b11, 5'd1, 5'd0, 5'd0, 1'b0);
        tick();
        drive(4'b1100, 3'b000, 2'b10, 5'd0, 5'd0, 5'd11, 1'b0);
        #1;
        check("zero_pc_write", pc_write, 1'b1);
        tick();
        check("zero_stall", stall_cnt, 2'd0);

        // Flush after a branch
        do_reset();
        drive(4'b0010, 3'b100, 2'b00, 5'd3, 5'd4, 5'd0, 1'b0);
        tick();
        drive(4'b1100, 3'b000, 2'b10, 5'd5, 5'd6, 5'd7, 1'b1);
        tick();
        check("flush_valid", valid_q, 1'b0);
        check("flush_ctrl", {ex_ctrl_q, mem_ctrl_q, wb_ctrl_q}, 9'd0);
        check("flush_bubble", bubble_cnt, 2'd1);

        // Flush and hazard together: flush wins
        do_reset();
        drive(4'b0001, 3'b010, 2'b11, 5'd1, 5'd5, 5'd0, 1'b0);
        tick();
        drive(4'b1100, 3'b000, 2'b10, 5'd5, 5'd6, 5'd7, 1'b1);
        #1;
        check("fh_pc_write", pc_write, 1'b1);
        tick();
        check("fh_valid", valid_q, 1'b0);
        check("fh_stall", stall_cnt, 2'd0);
        check("fh_bubble", bubble_cnt, 2'd1);

        // Saturation: 5 flushes into a 2-bit counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(4'b1100, 3'b000, 2'b10, 5'(i), 5'(i + 1), 5'(i + 2), 1'b1);
            tick();
        end
        check("sat_bubble", bubble_cnt, 2'd3);
        #2;
        reset = 1'b0;
        #1;
        check("async_cnt", {stall_cnt, bubble_cnt}, '0);
        reset = 1'b1;

        // Reset during a load-use stall
        drive(4'b0001, 3'b010, 2'b11, 5'd1, 5'd8, 5'd0, 1'b0);
        tick();
        drive(4'b1100, 3'b000, 2'b10, 5'd8, 5'd9, 5'd10, 1'b0);
        #1;
        check("ms_stall_seen", pc_write, 1'b0);
        reset = 1'b0;
        #1;
        check("ms_pc_write", pc_write, 1'b1);
        check("ms_valid", valid_q, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check("ms_after", pc_write, 1'b1);
        tick();
        check("ms_add_valid", valid_q, 1'b1);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
